// File: rtl/cmp_arbiter.sv
// Shared compare unit: round-robin arbitration between two requesters feeding one
// SLTU/SLT/SEQ datapath. One transaction in flight, tagged response held until accepted.
module cmp_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_rez,
    output logic             rsp_err,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Ready on either request port is only offered in IDLE; rsp_valid holds until rsp_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               last_grant;
    logic               grant;
    logic               any_valid;
    logic               accept;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               id_q;
    logic               res_bit;
    logic               res_err;

    // Round-robin: a lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign accept     = (state == IDLE) && any_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        res_bit = 1'b0;
        res_err = 1'b0;
        case (op_q)
            2'b00:   res_bit = (a_q < b_q);
            2'b01:   res_bit = ($signed(a_q) < $signed(b_q));
            2'b10:   res_bit = (a_q == b_q);
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_rez    <= '0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= grant ? req1_op : req0_op;
                a_q        <= grant ? req1_a  : req0_a;
                b_q        <= grant ? req1_b  : req0_b;
                id_q       <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_rez <= {{(WIDTH-1){1'b0}}, res_bit};
                rsp_err <= res_err;
                rsp_id  <= id_q;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: expected responses are queued at the request
// handshake and checked in order by an independent response monitor.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rez;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int rsp_cnt = 0;

    // Expected entry layout: {id, err, rez[15:0]}
    logic [17:0] exp_q[$];
    logic        grant_log[$];
    logic [17:0] pend0 = '0, pend1 = '0;

    cmp_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rez(rsp_rez), .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Request-side observer: push the requester's expected result when it is accepted
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back(pend0);
                grant_log.push_back(1'b0);
                hs_cnt++;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back(pend1);
                grant_log.push_back(1'b1);
                hs_cnt++;
            end
        end
    end

    // Scoreboard monitor: compare each accepted response against the queue head
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got=%0h want=none", {rsp_id, rsp_err, rsp_rez});
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({rsp_id, rsp_err, rsp_rez} !== e) begin
                    bad++;
                    $display("FAIL rsp got=%0h want=%0h", {rsp_id, rsp_err, rsp_rez}, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_q.delete();
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns 1 time unit after the accepting edge (DUT is then in EXEC)
    task automatic send(input bit port, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [17:0] exp);
        int start;
        int n;
        start = hs_cnt;
        n = 0;
        if (port == 1'b0) begin
            pend0 = exp; req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            pend1 = exp; req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        while (hs_cnt == start && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (hs_cnt == start) check("send_timeout", 32'(n), 32'(0));
        if (port == 1'b0) begin
            req0_valid = 1'b0;
            req0_a = 16'($urandom_range(0, 65535));
            req0_b = 16'($urandom_range(0, 65535));
        end else begin
            req1_valid = 1'b0;
            req1_a = 16'($urandom_range(0, 65535));
            req1_b = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk); n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int start;
        int n;
        int seen;

        do_reset();
        // Reset state, no requesters active
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rez", 32'(rsp_rez), 32'(0));
        check("rst_rsp_err_id", 32'({rsp_err, rsp_id}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_readies", 32'({req0_ready, req1_ready}), 32'(0));
        check("rst_state", 32'(state_dbg), 32'(0));
        @(posedge clk); #1;

        // Basic SLTU on port 0 with latency check
        pend0 = {1'b0, 1'b0, 16'h0001};
        req0_op = 2'b00; req0_a = 16'h0003; req0_b = 16'h0005; req0_valid = 1'b1;
        @(negedge clk);
        check("ready_same_cycle", 32'(req0_ready), 32'(1));
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("exec_no_valid", 32'(rsp_valid), 32'(0));
        check("exec_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("rsp_latency", 32'(rsp_valid), 32'(1));
        wait_idle();

        // Signed vs unsigned on port 1
        send(1'b1, 2'b01, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0001});
        wait_idle();
        send(1'b1, 2'b00, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000});
        wait_idle();
        send(1'b1, 2'b01, 16'h8000, 16'h7FFF, {1'b1, 1'b0, 16'h0001});
        wait_idle();

        // Both ports valid continuously: grants alternate starting at port 0
        do_reset();
        pend0 = {1'b0, 1'b0, 16'h0001};
        pend1 = {1'b1, 1'b0, 16'h0000};
        req0_op = 2'b10; req0_a = 16'h0005; req0_b = 16'h0005;
        req1_op = 2'b00; req1_a = 16'h0007; req1_b = 16'h0002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        start = hs_cnt;
        n = 0;
        while (hs_cnt < start + 4 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", 32'(grant_log.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("rr_grant", 32'(grant_log[i]), 32'(i % 2));
        end
        wait_idle();

        // Illegal op then SEQ on the same operands
        send(1'b0, 2'b11, 16'h1234, 16'h1234, {1'b0, 1'b1, 16'h0000});
        wait_idle();
        send(1'b0, 2'b10, 16'h1234, 16'h1234, {1'b0, 1'b0, 16'h0001});
        wait_idle();

        // Backpressure: hold RESP 10 cycles with a pending requester
        rsp_ready = 1'b0;
        send(1'b1, 2'b01, 16'hFFFE, 16'h0003, {1'b1, 1'b0, 16'h0001});
        pend0 = {1'b0, 1'b0, 16'h0001};
        req0_op = 2'b00; req0_a = 16'h0001; req0_b = 16'h0002; req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", 32'({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, busy, rsp_rez}),
                  32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        start = hs_cnt;
        @(negedge clk);
        check("release_cycle_ready", 32'(req0_ready), 32'(0));
        @(negedge clk);
        check("accept_after_release", 32'(req0_ready), 32'(1));
        @(posedge clk); #1 req0_valid = 1'b0;
        check("accept_count", 32'(hs_cnt - start), 32'(1));
        wait_idle();

        // Reset during EXEC drops the transaction; next tie goes to port 0
        do_reset();
        send(1'b1, 2'b10, 16'h0001, 16'h0001, {1'b1, 1'b0, 16'h0001});
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_rst", 32'(seen), 32'(0));
        @(posedge clk); #1;
        grant_log.delete();
        pend0 = {1'b0, 1'b0, 16'h0000};
        pend1 = {1'b1, 1'b0, 16'h0000};
        req0_op = 2'b00; req0_a = 16'h0009; req0_b = 16'h0002;
        req1_op = 2'b00; req1_a = 16'h0009; req1_b = 16'h0002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        start = hs_cnt;
        n = 0;
        while (hs_cnt == start && n < 100) begin
            @(posedge clk); #1; n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("tie_after_rst", 32'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 32'(0));
        wait_idle();

        // Final report
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("rsp_count", 32'(rsp_cnt), 32'(13));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
